// File: rtl/source_buffer_loader.sv
// source_buffer_loader: fills the source M10K from a sample stream or a constant fill,
// then holds START until the compute stage reports the frame consumed.
module source_buffer_loader #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH = 16,
  parameter int FILL_VALUE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              fill_req,
  input  logic              compute_done,
  output logic [DATA_W-1:0] M10K_write_data_source,
  output logic [ADDR_W-1:0] M10K_write_address_source,
  output logic              M10K_write_source,
  output logic              START,
  output logic              busy,
  output logic [ADDR_W:0]   load_count
);
  typedef enum logic [1:0] {LOAD, FILL, ARMED} state_t;
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [DATA_W-1:0] FILL_DATA = DATA_W'(FILL_VALUE);
  state_t state, state_d;
  logic [ADDR_W-1:0] idx, idx_d, addr_d;
  logic [ADDR_W:0] count_d;
  logic [DATA_W-1:0] data_d;
  logic wr_d, start_d, write, last;
  assign in_ready = reset & (state == LOAD) & ~fill_req;
  assign write = (state == FILL) | (in_valid & in_ready);
  assign last = load_count == LAST;
  assign busy = (state == FILL) | ((state == LOAD) & (idx != '0));
  // Terminal test uses load_count so DEPTH == 2**ADDR_W works with idx wrapping.
  always_comb begin
    state_d = state;
    idx_d = idx;
    count_d = load_count;
    addr_d = M10K_write_address_source;
    data_d = M10K_write_data_source;
    wr_d = write;
    start_d = (state == ARMED) & ~compute_done;
    if (state == LOAD && fill_req) begin
      state_d = FILL;
      idx_d = '0;
      count_d = '0;
    end
    if (write) begin
      addr_d = idx;
      data_d = (state == FILL) ? FILL_DATA : in_data;
      count_d = load_count + 1'b1;
      idx_d = last ? '0 : idx + 1'b1;
      state_d = last ? ARMED : state;
    end
    if (state == ARMED && compute_done) begin
      state_d = LOAD;
      count_d = '0;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= LOAD;
      idx <= '0;
      load_count <= '0;
      M10K_write_address_source <= '0;
      M10K_write_data_source <= '0;
      M10K_write_source <= 1'b0;
      START <= 1'b0;
    end else begin
      state <= state_d;
      idx <= idx_d;
      load_count <= count_d;
      M10K_write_address_source <= addr_d;
      M10K_write_data_source <= data_d;
      M10K_write_source <= wr_d;
      START <= start_d;
    end
  end
endmodule

// File: tb/tb_source_buffer_loader.sv
// tb_source_buffer_loader: directed scenarios with hand-computed expectations and an M10K model.
module tb_source_buffer_loader;
  logic clk = 0, reset = 0, in_valid = 0, fill_req = 0, compute_done = 0;
  logic [7:0] in_data = 0;
  logic in_ready, wr, start, busy;
  logic [7:0] wdata, waddr;
  logic [8:0] load_count;
  logic [7:0] mem [256];
  int tests = 0, fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) if (wr) mem[waddr] <= wdata;

  source_buffer_loader dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .fill_req(fill_req), .compute_done(compute_done),
    .M10K_write_data_source(wdata), .M10K_write_address_source(waddr),
    .M10K_write_source(wr), .START(start), .busy(busy), .load_count(load_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_done();
    compute_done = 1;
    step();
    compute_done = 0;
  endtask

  task automatic stream(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      in_valid = 1;
      in_data = 8'(base + i);
      step();
    end
    in_valid = 0;
  endtask

  task automatic test_reset();
    reset = 0;
    #3;
    tests++;
    if ({in_ready, wr, start, busy, waddr, wdata, load_count} !== 30'd0) begin
      fails++;
      $display("FAIL reset_outputs got %h want 0", {in_ready, wr, start, busy, waddr, wdata, load_count});
    end
    @(negedge clk);
    reset = 1;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) mem[i] = 8'hAA;
    fill_req = 1;
    step();
    fill_req = 0;
    tests++;
    if ({in_ready, busy, wr, load_count} !== {1'b0, 1'b1, 1'b0, 9'd0}) begin
      fails++;
      $display("FAIL fill_entry got %h want %h", {in_ready, busy, wr, load_count}, {1'b0, 1'b1, 1'b0, 9'd0});
    end
    for (int i = 0; i < 16; i++) begin
      step();
      tests++;
      if ({wr, waddr, wdata, start, load_count} !== {1'b1, 8'(i), 8'd1, 1'b0, 9'(i + 1)}) begin
        fails++;
        $display("FAIL fill_strobe%0d got %h want %h", i, {wr, waddr, wdata, start, load_count},
                 {1'b1, 8'(i), 8'd1, 1'b0, 9'(i + 1)});
      end
    end
    step();
    tests++;
    if ({wr, start, in_ready, busy, load_count} !== {1'b0, 1'b1, 1'b0, 1'b0, 9'd16}) begin
      fails++;
      $display("FAIL fill_armed got %h want %h", {wr, start, in_ready, busy, load_count},
               {1'b0, 1'b1, 1'b0, 1'b0, 9'd16});
    end
    for (int i = 0; i < 16; i++) begin
      tests++;
      if (mem[i] !== 8'd1) begin
        fails++;
        $display("FAIL fill_readback%0d got %h want 01", i, mem[i]);
      end
    end
  endtask

  task automatic test_stream();
    pulse_done();
    tests++;
    if ({start, in_ready, load_count} !== {1'b0, 1'b1, 9'd0}) begin
      fails++;
      $display("FAIL stream_rearm got %h want %h", {start, in_ready, load_count}, {1'b0, 1'b1, 9'd0});
    end
    for (int i = 0; i < 16; i++) begin
      in_valid = 1;
      in_data = 8'(i - 5);
      #1;
      tests++;
      if (in_ready !== 1'b1) begin
        fails++;
        $display("FAIL stream_ready%0d got %b want 1", i, in_ready);
      end
      step();
      in_valid = 0;
      tests++;
      if ({wr, waddr, wdata, start} !== {1'b1, 8'(i), 8'(i - 5), 1'b0}) begin
        fails++;
        $display("FAIL stream_strobe%0d got %h want %h", i, {wr, waddr, wdata, start}, {1'b1, 8'(i), 8'(i - 5), 1'b0});
      end
      step();
      tests++;
      if ({wr, waddr, wdata, start, in_ready} !== {1'b0, 8'(i), 8'(i - 5), i == 15, i != 15}) begin
        fails++;
        $display("FAIL stream_gap%0d got %h want %h", i, {wr, waddr, wdata, start, in_ready},
                 {1'b0, 8'(i), 8'(i - 5), i == 15, i != 15});
      end
    end
    for (int i = 0; i < 16; i++) begin
      tests++;
      if (mem[i] !== 8'(i - 5)) begin
        fails++;
        $display("FAIL stream_readback%0d got %h want %h", i, mem[i], 8'(i - 5));
      end
    end
  endtask

  task automatic test_armed_hold();
    in_valid = 1;
    in_data = 8'h55;
    for (int i = 0; i < 20; i++) begin
      fill_req = (i == 3);
      step();
      tests++;
      if ({start, wr, in_ready, load_count} !== {1'b1, 1'b0, 1'b0, 9'd16}) begin
        fails++;
        $display("FAIL armed_hold%0d got %h want %h", i, {start, wr, in_ready, load_count}, {1'b1, 1'b0, 1'b0, 9'd16});
      end
    end
    fill_req = 0;
    in_valid = 0;
    pulse_done();
    tests++;
    if ({start, in_ready, load_count, busy} !== {1'b0, 1'b1, 9'd0, 1'b0}) begin
      fails++;
      $display("FAIL armed_release got %h want %h", {start, in_ready, load_count, busy}, {1'b0, 1'b1, 9'd0, 1'b0});
    end
    for (int i = 0; i < 16; i++) begin
      in_valid = 1;
      in_data = 8'(3 * i - 20);
      step();
      tests++;
      if ({wr, waddr, wdata, load_count} !== {1'b1, 8'(i), 8'(3 * i - 20), 9'(i + 1)}) begin
        fails++;
        $display("FAIL frame2_strobe%0d got %h want %h", i, {wr, waddr, wdata, load_count},
                 {1'b1, 8'(i), 8'(3 * i - 20), 9'(i + 1)});
      end
    end
    in_valid = 0;
    step();
    tests++;
    if ({start, wr} !== 2'b10) begin
      fails++;
      $display("FAIL frame2_start got %b want 10", {start, wr});
    end
    for (int i = 0; i < 16; i++) begin
      tests++;
      if (mem[i] !== 8'(3 * i - 20)) begin
        fails++;
        $display("FAIL frame2_readback%0d got %h want %h", i, mem[i], 8'(3 * i - 20));
      end
    end
  endtask

  task automatic test_fill_priority();
    pulse_done();
    stream(5, 40);
    in_valid = 1;
    in_data = 8'd99;
    fill_req = 1;
    #1;
    tests++;
    if (in_ready !== 1'b0) begin
      fails++;
      $display("FAIL prio_ready got %b want 0", in_ready);
    end
    step();
    fill_req = 0;
    in_valid = 0;
    tests++;
    if ({wr, load_count, busy} !== {1'b0, 9'd0, 1'b1}) begin
      fails++;
      $display("FAIL prio_entry got %h want %h", {wr, load_count, busy}, {1'b0, 9'd0, 1'b1});
    end
    for (int i = 0; i < 16; i++) begin
      step();
      tests++;
      if ({wr, waddr, wdata, load_count} !== {1'b1, 8'(i), 8'd1, 9'(i + 1)}) begin
        fails++;
        $display("FAIL prio_strobe%0d got %h want %h", i, {wr, waddr, wdata, load_count}, {1'b1, 8'(i), 8'd1, 9'(i + 1)});
      end
    end
    step();
    tests++;
    if ({start, wr} !== 2'b10) begin
      fails++;
      $display("FAIL prio_start got %b want 10", {start, wr});
    end
    for (int i = 0; i < 16; i++) begin
      tests++;
      if (mem[i] !== 8'd1) begin
        fails++;
        $display("FAIL prio_readback%0d got %h want 01", i, mem[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    pulse_done();
    stream(7, 1);
    #2;
    reset = 0;
    #1;
    tests++;
    if ({in_ready, wr, start, busy, waddr, wdata, load_count} !== 30'd0) begin
      fails++;
      $display("FAIL async_reset got %h want 0", {in_ready, wr, start, busy, waddr, wdata, load_count});
    end
    @(negedge clk);
    reset = 1;
    #1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1;
      in_data = 8'(100 - i);
      step();
      tests++;
      if ({wr, waddr, wdata, start} !== {1'b1, 8'(i), 8'(100 - i), 1'b0}) begin
        fails++;
        $display("FAIL rst_restart%0d got %h want %h", i, {wr, waddr, wdata, start}, {1'b1, 8'(i), 8'(100 - i), 1'b0});
      end
    end
    in_valid = 0;
    step();
    tests++;
    if ({start, load_count} !== {1'b1, 9'd16}) begin
      fails++;
      $display("FAIL rst_start got %h want %h", {start, load_count}, {1'b1, 9'd16});
    end
  endtask

  task automatic test_ignored();
    pulse_done();
    stream(3, 7);
    pulse_done();
    tests++;
    if ({wr, load_count, busy, start, in_ready} !== {1'b0, 9'd3, 1'b1, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL ign_done_load got %h want %h", {wr, load_count, busy, start, in_ready},
               {1'b0, 9'd3, 1'b1, 1'b0, 1'b1});
    end
    fill_req = 1;
    step();
    in_valid = 1;
    in_data = 8'h77;
    for (int i = 0; i < 16; i++) begin
      fill_req = (i == 4);
      compute_done = (i == 8);
      step();
      tests++;
      if ({wr, waddr, wdata, start, in_ready, load_count} !== {1'b1, 8'(i), 8'd1, 1'b0, 1'b0, 9'(i + 1)}) begin
        fails++;
        $display("FAIL ign_fill%0d got %h want %h", i, {wr, waddr, wdata, start, in_ready, load_count},
                 {1'b1, 8'(i), 8'd1, 1'b0, 1'b0, 9'(i + 1)});
      end
    end
    fill_req = 0;
    compute_done = 0;
    step();
    in_valid = 0;
    tests++;
    if ({start, wr, in_ready} !== 3'b100) begin
      fails++;
      $display("FAIL ign_armed got %b want 100", {start, wr, in_ready});
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_stream();
    test_armed_hold();
    test_fill_priority();
    test_async_reset();
    test_ignored();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
